// File: rtl/epu_in_axi_bridge.sv
// AXI4 slave front end for the EPU input buffer: turns AR/R and AW/W/B bursts
// into per-beat SRAM handshake strobes for Input_wrapper.
module epu_in_axi_bridge #(
  parameter int unsigned       ID_W   = 8,
  parameter int unsigned       ADDR_W = 32,
  parameter int unsigned       DATA_W = 32,
  parameter int unsigned       LEN_W  = 4,
  parameter logic [ADDR_W-1:0] BASE   = 32'h0040_0000,
  parameter logic [ADDR_W-1:0] SIZE   = 32'h0006_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   arid_i,
  input  logic [ADDR_W-1:0] araddr_i,
  input  logic [LEN_W-1:0]  arlen_i,
  input  logic              arvalid_i,
  output logic              arready_o,
  output logic [ID_W-1:0]   rid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [1:0]        rresp_o,
  output logic              rlast_o,
  output logic              rvalid_o,
  input  logic              rready_i,
  input  logic [ID_W-1:0]   awid_i,
  input  logic [ADDR_W-1:0] awaddr_i,
  input  logic [LEN_W-1:0]  awlen_i,
  input  logic              awvalid_i,
  output logic              awready_o,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              wvalid_i,
  output logic              wready_o,
  output logic [ID_W-1:0]   bid_o,
  output logic [1:0]        bresp_o,
  output logic              bvalid_o,
  input  logic              bready_i,
  input  logic              epu_busy_i,
  input  logic              wrp_rvalid_i,
  input  logic [DATA_W-1:0] wrp_rdata_i,
  output logic              enb_o,
  output logic              cs_o,
  output logic              oe_o,
  output logic              arhns_o,
  output logic              awhns_o,
  output logic              rhns_o,
  output logic              whns_o,
  output logic              rdfin_o,
  output logic              wrfin_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdata_o
);

  typedef enum logic [2:0] {IDLE, R_WAIT, R_DATA, W_WAIT, W_DATA, W_RESP} state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  state_t            r_state, w_next;
  logic [ID_W-1:0]   r_id;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_beat;
  logic              r_hit;

  logic w_idle_rdy, w_ar_acc, w_aw_acc, w_ar_hit, w_aw_hit;
  logic w_last, w_rvalid, w_rbeat, w_wbeat;

  // Unsigned wrap makes addresses below BASE compare as huge offsets.
  assign w_ar_hit   = (araddr_i - BASE) < SIZE;
  assign w_aw_hit   = (awaddr_i - BASE) < SIZE;
  assign w_idle_rdy = (r_state == IDLE) && !epu_busy_i;
  assign w_ar_acc   = w_idle_rdy && arvalid_i;
  assign w_aw_acc   = w_idle_rdy && awvalid_i && !arvalid_i;
  assign w_last     = (r_beat == r_len);
  assign w_rvalid   = (r_state == R_DATA) && (r_hit ? wrp_rvalid_i : 1'b1);
  assign w_rbeat    = w_rvalid && rready_i;
  assign w_wbeat    = (r_state == W_DATA) && wvalid_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:   if (w_ar_acc) w_next = R_WAIT;
              else if (w_aw_acc) w_next = W_WAIT;
      R_WAIT: w_next = R_DATA;
      R_DATA: if (w_rbeat) w_next = w_last ? IDLE : R_WAIT;
      W_WAIT: w_next = W_DATA;
      W_DATA: if (w_wbeat && w_last) w_next = W_RESP;
      W_RESP: if (bready_i) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id   <= '0;
      r_addr <= '0;
      r_len  <= '0;
      r_beat <= '0;
      r_hit  <= 1'b0;
    end else if (w_ar_acc) begin
      r_id   <= arid_i;
      r_addr <= araddr_i;
      r_len  <= arlen_i;
      r_beat <= '0;
      r_hit  <= w_ar_hit;
    end else if (w_aw_acc) begin
      r_id   <= awid_i;
      r_addr <= awaddr_i;
      r_len  <= awlen_i;
      r_beat <= '0;
      r_hit  <= w_aw_hit;
    end else if ((w_rbeat || w_wbeat) && !w_last) begin
      r_beat <= r_beat + LEN_W'(1);
      r_addr <= r_addr + ADDR_W'(4);
    end
  end

  // AR has priority, so AW is only offered when no read is pending.
  always_comb begin
    arready_o = w_idle_rdy;
    awready_o = w_idle_rdy && !arvalid_i;
    arhns_o   = w_ar_acc && w_ar_hit;
    awhns_o   = w_aw_acc && w_aw_hit;
    rid_o     = '0;
    rdata_o   = '0;
    rresp_o   = RESP_OKAY;
    rlast_o   = 1'b0;
    rvalid_o  = 1'b0;
    rhns_o    = 1'b0;
    rdfin_o   = 1'b0;
    wready_o  = 1'b0;
    whns_o    = 1'b0;
    wrfin_o   = 1'b0;
    wdata_o   = '0;
    bid_o     = '0;
    bresp_o   = RESP_OKAY;
    bvalid_o  = 1'b0;
    enb_o     = (r_state != IDLE) && r_hit;
    cs_o      = enb_o;
    oe_o      = enb_o && ((r_state == R_WAIT) || (r_state == R_DATA));
    addr_o    = (r_state != IDLE) ? (r_addr - BASE) : '0;
    unique case (r_state)
      R_DATA: begin
        rvalid_o = w_rvalid;
        rid_o    = r_id;
        rdata_o  = r_hit ? wrp_rdata_i : '0;
        rresp_o  = r_hit ? RESP_OKAY : RESP_DECERR;
        rlast_o  = w_last;
        rhns_o   = w_rbeat && r_hit;
        rdfin_o  = w_rbeat && r_hit && w_last;
      end
      W_DATA: begin
        wready_o = 1'b1;
        whns_o   = wvalid_i && r_hit;
        wrfin_o  = wvalid_i && r_hit && w_last;
        wdata_o  = wdata_i;
      end
      W_RESP: begin
        bvalid_o = 1'b1;
        bid_o    = r_id;
        bresp_o  = r_hit ? RESP_OKAY : RESP_DECERR;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_epu_in_axi_bridge.sv
// Bench for epu_in_axi_bridge: table of bursts, hand-written corner sequences
// and random bursts, checked against a word-memory reference model.
module tb_epu_in_axi_bridge;

  localparam logic [31:0] BASE = 32'h0040_0000;
  localparam logic [31:0] SIZE = 32'h0006_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  arid_i, awid_i, rid_o, bid_o;
  logic [31:0] araddr_i, awaddr_i, rdata_o, wdata_i, wrp_rdata_i, addr_o, wdata_o;
  logic [3:0]  arlen_i, awlen_i;
  logic        arvalid_i, arready_o, rlast_o, rvalid_o, rready_i;
  logic        awvalid_i, awready_o, wvalid_i, wready_o, bvalid_o, bready_i;
  logic [1:0]  rresp_o, bresp_o;
  logic        epu_busy_i, wrp_rvalid_i;
  logic        enb_o, cs_o, oe_o, arhns_o, awhns_o, rhns_o, whns_o, rdfin_o, wrfin_o;

  epu_in_axi_bridge #(.ID_W(8), .ADDR_W(32), .DATA_W(32), .LEN_W(4), .BASE(BASE), .SIZE(SIZE)) dut (
    .clk(clk), .rst(rst),
    .arid_i(arid_i), .araddr_i(araddr_i), .arlen_i(arlen_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
    .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
    .awid_i(awid_i), .awaddr_i(awaddr_i), .awlen_i(awlen_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
    .wdata_i(wdata_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
    .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
    .epu_busy_i(epu_busy_i), .wrp_rvalid_i(wrp_rvalid_i), .wrp_rdata_i(wrp_rdata_i),
    .enb_o(enb_o), .cs_o(cs_o), .oe_o(oe_o), .arhns_o(arhns_o), .awhns_o(awhns_o),
    .rhns_o(rhns_o), .whns_o(whns_o), .rdfin_o(rdfin_o), .wrfin_o(wrfin_o),
    .addr_o(addr_o), .wdata_o(wdata_o)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [31:0] ref_mem  [int unsigned];
  logic [31:0] wrap_mem [int unsigned];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [7:0]  id;
    bit          exp_hit;
  } vec_t;

  function automatic logic [31:0] init_word(int unsigned k);
    return 32'h5EED_0000 ^ (k * 32'h0000_9E37);
  endfunction

  function automatic logic [31:0] ref_rd(int unsigned k);
    return ref_mem.exists(k) ? ref_mem[k] : init_word(k);
  endfunction

  function automatic logic [31:0] wrap_rd(int unsigned k);
    return wrap_mem.exists(k) ? wrap_mem[k] : init_word(k);
  endfunction

  function automatic bit model_hit(logic [31:0] a);
    logic [32:0] lo, hi;
    lo = {1'b0, BASE};
    hi = {1'b0, BASE} + {1'b0, SIZE};
    return ({1'b0, a} >= lo) && ({1'b0, a} < hi);
  endfunction

  function automatic int unsigned word_key(logic [31:0] a, int unsigned b);
    logic [31:0] off;
    off = a - BASE + 32'(4 * b);
    return int'(off >> 2);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Wrapper emulation: read data follows the DUT address, writes land on whns.
  task automatic settle();
    wrp_rdata_i = wrap_rd(int'(addr_o >> 2));
    #1;
  endtask

  task automatic adv();
    if (whns_o) wrap_mem[int'(addr_o >> 2)] = wdata_o;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [3:0] len, input logic [7:0] id,
                         input bit exp_hit, input int unsigned busy_cyc, input bit gappy,
                         input int unsigned stall);
    logic [31:0] exp_d;
    bit done;
    int unsigned guard;
    int unsigned st;
    epu_busy_i = 1'b1; arvalid_i = 1'b1; araddr_i = a; arlen_i = len; arid_i = id;
    for (int unsigned i = 0; i < busy_cyc; i++) begin
      settle();
      chk("busy_arready", arready_o, 0);
      chk("busy_arhns", arhns_o, 0);
      adv();
    end
    epu_busy_i = 1'b0;
    settle();
    chk("arready", arready_o, 1);
    chk("arhns", arhns_o, exp_hit);
    chk("idle_enb", enb_o, 0);
    if (awvalid_i) chk("ar_priority_awhns", awhns_o, 0);
    adv();
    arvalid_i = 1'b0;
    for (int unsigned b = 0; b <= len; b++) begin
      rready_i = gappy ? 1'($urandom_range(0, 1)) : 1'b1;
      epu_busy_i = gappy ? 1'($urandom_range(0, 1)) : 1'b0;
      settle();
      chk("rwait_rvalid", rvalid_o, 0);
      chk("rwait_oe", oe_o, exp_hit);
      chk("rwait_enb", enb_o, exp_hit);
      adv();
      exp_d = exp_hit ? ref_rd(word_key(a, b)) : 32'h0;
      done = 1'b0; guard = 0; st = stall;
      while (!done && guard < 64) begin
        wrp_rvalid_i = (gappy && st == 0) ? ($urandom_range(0, 9) < 7) : 1'b1;
        rready_i = (st > 0) ? 1'b0 : (gappy ? ($urandom_range(0, 9) < 7) : 1'b1);
        if (st > 0) st--;
        epu_busy_i = gappy ? 1'($urandom_range(0, 1)) : 1'b0;
        settle();
        chk("rvalid", rvalid_o, exp_hit ? wrp_rvalid_i : 1'b1);
        if (rvalid_o) begin
          chk("rdata", rdata_o, exp_d);
          chk("rresp", rresp_o, exp_hit ? 2'b00 : 2'b11);
          chk("rlast", rlast_o, b == len);
          chk("rid", rid_o, id);
        end
        chk("rhns", rhns_o, exp_hit && rvalid_o && rready_i);
        chk("rdfin", rdfin_o, exp_hit && rvalid_o && rready_i && b == len);
        if (exp_hit) chk("raddr", addr_o, a - BASE + 32'(4 * b));
        if (rvalid_o && rready_i) done = 1'b1;
        adv();
        guard++;
      end
      chk("r_beat_done", done, 1);
    end
    rready_i = 1'b0; wrp_rvalid_i = 1'b0; epu_busy_i = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [3:0] len, input logic [7:0] id,
                          input bit exp_hit, input bit gappy, input logic [31:0] d0);
    bit done;
    int unsigned guard;
    int unsigned b;
    awvalid_i = 1'b1; awaddr_i = a; awlen_i = len; awid_i = id;
    settle();
    chk("awready", awready_o, 1);
    chk("awhns", awhns_o, exp_hit);
    adv();
    awvalid_i = 1'b0;
    wvalid_i = 1'b1; wdata_i = 32'hDEAD_BEEF;
    settle();
    chk("wwait_wready", wready_o, 0);
    chk("wwait_whns", whns_o, 0);
    chk("wwait_enb", enb_o, exp_hit);
    adv();
    b = 0; guard = 0;
    while (b <= len && guard < 128) begin
      wvalid_i = gappy ? ($urandom_range(0, 9) < 6) : 1'b1;
      wdata_i = d0 + 32'(b);
      epu_busy_i = gappy ? 1'($urandom_range(0, 1)) : 1'b0;
      settle();
      chk("wready", wready_o, 1);
      chk("whns", whns_o, wvalid_i && exp_hit);
      chk("wrfin", wrfin_o, wvalid_i && exp_hit && b == len);
      chk("w_oe", oe_o, 0);
      if (exp_hit) chk("waddr", addr_o, a - BASE + 32'(4 * b));
      if (wvalid_i) begin
        if (exp_hit) chk("wdata_o", wdata_o, d0 + 32'(b));
        if (exp_hit) ref_mem[word_key(a, b)] = d0 + 32'(b);
        b++;
      end
      adv();
      guard++;
    end
    chk("w_beats_done", b, 32'(len) + 1);
    wvalid_i = 1'b0;
    done = 1'b0; guard = 0;
    while (!done && guard < 64) begin
      bready_i = gappy ? ($urandom_range(0, 9) < 6) : 1'b1;
      settle();
      chk("bvalid", bvalid_o, 1);
      chk("bid", bid_o, id);
      chk("bresp", bresp_o, exp_hit ? 2'b00 : 2'b11);
      if (bready_i) done = 1'b1;
      adv();
      guard++;
    end
    chk("b_done", done, 1);
    bready_i = 1'b0; epu_busy_i = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_rvalid"}, rvalid_o, 0);
    chk({tag, "_bvalid"}, bvalid_o, 0);
    chk({tag, "_wready"}, wready_o, 0);
    chk({tag, "_enb"}, enb_o, 0);
    chk({tag, "_cs"}, cs_o, 0);
    chk({tag, "_oe"}, oe_o, 0);
    chk({tag, "_whns"}, whns_o, 0);
    chk({tag, "_wrfin"}, wrfin_o, 0);
    chk({tag, "_addr"}, addr_o, 0);
  endtask

  vec_t tbl[9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    tbl[0] = '{1'b1, BASE,                 4'd3,  8'h05, 1'b1};
    tbl[1] = '{1'b0, BASE,                 4'd3,  8'h06, 1'b1};
    tbl[2] = '{1'b0, BASE + SIZE,          4'd1,  8'h07, 1'b0};
    tbl[3] = '{1'b0, BASE - 32'd4,         4'd0,  8'h01, 1'b0};
    tbl[4] = '{1'b1, BASE + SIZE - 32'd4,  4'd0,  8'h02, 1'b1};
    tbl[5] = '{1'b1, BASE + SIZE,          4'd2,  8'h09, 1'b0};
    tbl[6] = '{1'b0, BASE + SIZE - 32'd4,  4'd0,  8'h04, 1'b1};
    tbl[7] = '{1'b1, 32'h0000_0000,        4'd15, 8'hAA, 1'b0};
    tbl[8] = '{1'b0, BASE + 32'h100,       4'd15, 8'h3C, 1'b1};

    rst = 1'b1;
    arid_i = '0; araddr_i = '0; arlen_i = '0; arvalid_i = 1'b0; rready_i = 1'b0;
    awid_i = '0; awaddr_i = '0; awlen_i = '0; awvalid_i = 1'b0;
    wdata_i = '0; wvalid_i = 1'b0; bready_i = 1'b0;
    epu_busy_i = 1'b0; wrp_rvalid_i = 1'b0; wrp_rdata_i = '0;
    repeat (2) @(negedge clk);
    settle();
    chk_quiet("reset");
    chk("reset_arhns", arhns_o, 0);
    rst = 1'b0;
    @(negedge clk);
    settle();
    chk("post_reset_arready", arready_o, 1);
    chk("post_reset_awready", awready_o, 1);

    do_read(BASE + 32'd8, 4'd0, 8'd3, 1'b1, 0, 1'b0, 0);
    do_write(BASE, 4'd3, 8'h21, 1'b1, 1'b1, 32'hA);
    do_read(BASE, 4'd3, 8'h22, 1'b1, 0, 1'b0, 0);

    awvalid_i = 1'b1; awaddr_i = BASE + 32'h20; awlen_i = 4'd1; awid_i = 8'h33;
    do_read(BASE + 32'h20, 4'd1, 8'h34, 1'b1, 0, 1'b1, 0);
    do_write(BASE + 32'h20, 4'd1, 8'h33, 1'b1, 1'b0, 32'h1234_0000);
    do_read(BASE + 32'h20, 4'd1, 8'h35, 1'b1, 0, 1'b0, 0);

    do_read(BASE + SIZE, 4'd1, 8'h44, 1'b0, 0, 1'b0, 0);
    do_read(BASE + 32'h40, 4'd0, 8'h55, 1'b1, 3, 1'b0, 3);

    for (int unsigned i = 0; i < 9; i++) begin
      if (tbl[i].wr) do_write(tbl[i].addr, tbl[i].len, tbl[i].id, tbl[i].exp_hit, 1'b1, $urandom);
      else           do_read(tbl[i].addr, tbl[i].len, tbl[i].id, tbl[i].exp_hit, 0, 1'b1, 0);
    end

    // Reset during beat 2 of a 4-beat write
    awvalid_i = 1'b1; awaddr_i = BASE + 32'h80; awlen_i = 4'd3; awid_i = 8'h66;
    settle(); chk("rst_seq_awhns", awhns_o, 1); adv();
    awvalid_i = 1'b0; wvalid_i = 1'b0;
    settle(); adv();
    for (int unsigned b = 0; b < 2; b++) begin
      wvalid_i = 1'b1; wdata_i = 32'h7700 + 32'(b);
      settle();
      chk("rst_seq_whns", whns_o, 1);
      ref_mem[word_key(BASE + 32'h80, b)] = 32'h7700 + 32'(b);
      adv();
    end
    wdata_i = 32'h7702; rst = 1'b1;
    settle();
    chk_quiet("rst_async");
    adv();
    settle();
    chk_quiet("rst_held");
    rst = 1'b0; wvalid_i = 1'b0; bready_i = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      settle();
      chk("rst_no_bvalid", bvalid_o, 0);
      adv();
    end
    bready_i = 1'b0;
    do_read(BASE + 32'h80, 4'd3, 8'h67, 1'b1, 0, 1'b0, 0);
    do_write(BASE + 32'h80, 4'd3, 8'h68, 1'b1, 1'b0, 32'hC0C0_0000);
    do_read(BASE + 32'h80, 4'd3, 8'h69, 1'b1, 0, 1'b1, 0);

    for (int unsigned i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) < 3) a = BASE + 32'(4 * $urandom_range(0, 48));
      else                          a = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 1) == 1)
        do_write(a, 4'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), model_hit(a), 1'b1, $urandom);
      else
        do_read(a, 4'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), model_hit(a),
                $urandom_range(0, 2), 1'b1, $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
